// File: rtl/handshake_rx_fifo.sv
// Four-phase handshake receiver: synchronises an asynchronous req_i, captures
// one word per transaction into a first-word fall-through buffer.
module handshake_rx_fifo #(
  parameter int DW          = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_i,
  input  logic [DW-1:0]            req_data_i,
  output logic                     ack_o,
  output logic [DW-1:0]            recv_data_o,
  output logic                     recv_vld_o,
  input  logic                     recv_rdy_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    IDLE     = 1'b0,
    DEASSERT = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  state_e                 state_q;
  logic                   ack_q;
  logic [AW-1:0]          wr_ptr_q;
  logic [AW-1:0]          rd_ptr_q;
  logic [CW-1:0]          count_q;
  logic [CW-1:0]          count_d;
  logic [DW-1:0]          mem_q [DEPTH];
  logic                   full;
  logic                   push;
  logic                   pop;

  assign req_s = sync_q[SYNC_STAGES-1];

  // Full is judged on the registered count, so a pop in the full cycle
  // cannot make room for a push in that same cycle.
  assign full = (count_q == CW'(DEPTH));
  assign push = (state_q == IDLE) && req_s && !full;
  assign pop  = (count_q != '0) && recv_rdy_i;

  always_comb begin
    // NOTE: default assignment first, so no path through this block can infer a latch.
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (push) begin
            ack_q   <= 1'b1;
            state_q <= DEASSERT;
          end
        end
        DEASSERT: begin
          if (!req_s) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // NOTE: storage is deliberately not reset; stale words are never visible
  // because the output is masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= req_data_i;
  end

  assign ack_o       = ack_q;
  assign count_o     = count_q;
  assign recv_vld_o  = (count_q != '0);
  assign recv_data_o = recv_vld_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_handshake_rx_fifo.sv
// Directed bench for handshake_rx_fifo (DW=32, DEPTH=4, SYNC_STAGES=2).
module tb_handshake_rx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic [31:0] req_data_i;
  logic        ack_o;
  logic [31:0] recv_data_o;
  logic        recv_vld_o;
  logic        recv_rdy_i;
  logic [2:0]  count_o;

  int checks   = 0;
  int failures = 0;

  handshake_rx_fifo #(.DW(32), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .req_data_i  (req_data_i),
    .ack_o       (ack_o),
    .recv_data_o (recv_data_o),
    .recv_vld_o  (recv_vld_o),
    .recv_rdy_i  (recv_rdy_i),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ack(input logic v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (ack_o === v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send(input logic [31:0] d, output bit ok);
    bit ok1, ok2;
    req_data_i = d;
    req_i      = 1'b1;
    wait_ack(1'b1, ok1);
    req_i      = 1'b0;
    wait_ack(1'b0, ok2);
    ok = ok1 && ok2;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack_o); end
    checks++;
    if (count_o !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    checks++;
    if (recv_vld_o !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", recv_vld_o); end
    checks++;
    if (recv_data_o !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", recv_data_o); end
  endtask

  task automatic test_single();
    recv_rdy_i = 1'b1;
    req_data_i = 32'hA5A5_0001;
    req_i      = 1'b1;
    tick();
    tick();
    checks++;
    if (ack_o !== 1'b0) begin failures++; $display("FAIL single_ack_edge2 got=%b exp=0", ack_o); end
    tick();
    checks++;
    if (ack_o !== 1'b1) begin failures++; $display("FAIL single_ack_edge3 got=%b exp=1", ack_o); end
    checks++;
    if (recv_vld_o !== 1'b1 || count_o !== 3'd1) begin
      failures++; $display("FAIL single_vld_edge3 got vld=%b cnt=%0d exp vld=1 cnt=1", recv_vld_o, count_o);
    end
    checks++;
    if (recv_data_o !== 32'hA5A5_0001) begin failures++; $display("FAIL single_data got=%h exp=a5a50001", recv_data_o); end
    tick();
    checks++;
    if (count_o !== 3'd0 || recv_vld_o !== 1'b0 || recv_data_o !== 32'h0) begin
      failures++; $display("FAIL single_pop got cnt=%0d vld=%b data=%h exp 0/0/0", count_o, recv_vld_o, recv_data_o);
    end
    req_i = 1'b0;
    tick();
    tick();
    checks++;
    if (ack_o !== 1'b1) begin failures++; $display("FAIL single_ack_hold got=%b exp=1", ack_o); end
    tick();
    checks++;
    if (ack_o !== 1'b0) begin failures++; $display("FAIL single_ack_fall got=%b exp=0", ack_o); end
    recv_rdy_i = 1'b0;
  endtask

  task automatic test_fill_and_full_pop();
    bit ok;
    recv_rdy_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send(32'(i), ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL fill_send%0d got=timeout exp=handshake", i); end
    end
    checks++;
    if (count_o !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count_o); end
    req_data_i = 32'd5;
    req_i      = 1'b1;
    repeat (10) tick();
    checks++;
    if (ack_o !== 1'b0 || count_o !== 3'd4) begin
      failures++; $display("FAIL full_backpressure got ack=%b cnt=%0d exp ack=0 cnt=4", ack_o, count_o);
    end
    checks++;
    if (recv_data_o !== 32'd1) begin failures++; $display("FAIL drain_0 got=%h exp=1", recv_data_o); end
    recv_rdy_i = 1'b1;
    tick();
    recv_rdy_i = 1'b0;
    checks++;
    if (count_o !== 3'd3 || ack_o !== 1'b0) begin
      failures++; $display("FAIL full_pop_no_push got cnt=%0d ack=%b exp cnt=3 ack=0", count_o, ack_o);
    end
    tick();
    checks++;
    if (count_o !== 3'd4 || ack_o !== 1'b1) begin
      failures++; $display("FAIL full_push_after got cnt=%0d ack=%b exp cnt=4 ack=1", count_o, ack_o);
    end
    req_i = 1'b0;
    wait_ack(1'b0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL full_ack_release got=timeout exp=ack_low"); end
    for (int i = 2; i <= 5; i++) begin
      checks++;
      if (recv_vld_o !== 1'b1 || recv_data_o !== 32'(i)) begin
        failures++; $display("FAIL drain_%0d got vld=%b data=%h exp vld=1 data=%h", i, recv_vld_o, recv_data_o, 32'(i));
      end
      recv_rdy_i = 1'b1;
      tick();
      recv_rdy_i = 1'b0;
    end
    checks++;
    if (count_o !== 3'd0) begin failures++; $display("FAIL drain_empty got=%0d exp=0", count_o); end
  endtask

  task automatic test_long_req();
    int max_cnt = 0;
    recv_rdy_i = 1'b0;
    req_data_i = 32'h0000_0077;
    req_i      = 1'b1;
    repeat (20) begin
      tick();
      if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
    end
    checks++;
    if (max_cnt != 1 || count_o !== 3'd1) begin
      failures++; $display("FAIL long_one_write got max=%0d cnt=%0d exp 1/1", max_cnt, count_o);
    end
    req_i = 1'b0;
    tick();
    tick();
    checks++;
    if (ack_o !== 1'b1) begin failures++; $display("FAIL long_ack_hold got=%b exp=1", ack_o); end
    tick();
    checks++;
    if (ack_o !== 1'b0) begin failures++; $display("FAIL long_ack_fall got=%b exp=0", ack_o); end
    checks++;
    if (recv_data_o !== 32'h77) begin failures++; $display("FAIL long_data got=%h exp=77", recv_data_o); end
    recv_rdy_i = 1'b1;
    tick();
    recv_rdy_i = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] got[$];
    int          over = 0;
    int          send_fail = 0;
    recv_rdy_i = 1'b0;
    fork
      begin
        bit ok;
        for (int i = 0; i < 10; i++) begin
          send(32'h100 + 32'(i), ok);
          if (!ok) send_fail++;
        end
      end
      begin
        for (int c = 0; c < 600 && got.size() < 10; c++) begin
          @(negedge clk);
          if (count_o > 3'd4) over++;
          if (recv_vld_o && recv_rdy_i) got.push_back(recv_data_o);
          @(posedge clk);
          #1;
          recv_rdy_i = ~recv_rdy_i;
        end
      end
    join
    recv_rdy_i = 1'b0;
    checks++;
    if (send_fail != 0) begin failures++; $display("FAIL wrap_send got=%0d timeouts exp=0", send_fail); end
    checks++;
    if (over != 0) begin failures++; $display("FAIL wrap_count_bound got=%0d overflows exp=0", over); end
    checks++;
    if (got.size() != 10) begin
      failures++; $display("FAIL wrap_size got=%0d exp=10", got.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (got[i] !== 32'h100 + 32'(i)) begin
          failures++; $display("FAIL wrap_order%0d got=%h exp=%h", i, got[i], 32'h100 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    recv_rdy_i = 1'b0;
    send(32'hB0, ok);
    req_data_i = 32'hB1;
    req_i      = 1'b1;
    wait_ack(1'b1, ok);
    checks++;
    if (!ok || count_o !== 3'd2) begin
      failures++; $display("FAIL rstmid_setup got ok=%b cnt=%0d exp ok=1 cnt=2", ok, count_o);
    end
    req_data_i = 32'hC0;
    apply_reset();
    checks++;
    if (count_o !== 3'd0 || ack_o !== 1'b0 || recv_vld_o !== 1'b0 || recv_data_o !== 32'h0) begin
      failures++; $display("FAIL rstmid_clear got cnt=%0d ack=%b vld=%b data=%h exp 0/0/0/0",
                           count_o, ack_o, recv_vld_o, recv_data_o);
    end
    tick();
    tick();
    tick();
    checks++;
    if (ack_o !== 1'b1 || count_o !== 3'd1 || recv_data_o !== 32'hC0) begin
      failures++; $display("FAIL rstmid_recapture got ack=%b cnt=%0d data=%h exp 1/1/c0", ack_o, count_o, recv_data_o);
    end
    req_i = 1'b0;
    wait_ack(1'b0, ok);
    recv_rdy_i = 1'b1;
    tick();
    recv_rdy_i = 1'b0;
    checks++;
    if (count_o !== 3'd0) begin failures++; $display("FAIL rstmid_drain got=%0d exp=0", count_o); end
  endtask

  initial begin
    rst        = 1'b0;
    req_i      = 1'b0;
    req_data_i = '0;
    recv_rdy_i = 1'b0;
    #2;
    test_reset();
    test_single();
    test_fill_and_full_pop();
    test_long_req();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/handshake_rx_fifo.md
HANDSHAKE_RX_FIFO -- requirements
Module: handshake_rx_fifo

Interface
REQ-001 The module SHALL have parameter DW, default 32, giving the data width in bits (DW >= 1).
REQ-002 The module SHALL have parameter DEPTH, default 4, giving the receive buffer depth in entries (power of 2, DEPTH >= 2).
REQ-003 The module SHALL have parameter SYNC_STAGES, default 2, giving the number of req_i synchroniser flops (SYNC_STAGES >= 2).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_i  input  1  four-phase request from the transmitting domain; asynchronous to clk.
REQ-007 req_data_i  input  DW  transmit data; stable while req_i is high.
REQ-008 ack_o  output  1  four-phase acknowledge to the transmitter; registered.
REQ-009 recv_data_o  output  DW  head-of-buffer data (first-word fall-through).
REQ-010 recv_vld_o  output  1  buffer non-empty; recv_data_o is valid.
REQ-011 recv_rdy_i  input  1  consumer accepts the head entry when recv_vld_o is also high.
REQ-012 count_o  output  $clog2(DEPTH)+1  number of buffered entries, 0..DEPTH.

Function
REQ-013 req_i SHALL pass through SYNC_STAGES flops; only the last stage, req_s, SHALL drive logic.
REQ-014 The FSM SHALL have two states: IDLE and DEASSERT.
REQ-015 IDLE with req_s=1 and count_o<DEPTH SHALL, on the next edge, write req_data_i into the buffer tail, set ack_o=1 and move to DEASSERT.
REQ-016 IDLE with req_s=1 and count_o==DEPTH SHALL hold ack_o=0, stay in IDLE and write nothing (backpressure); capture SHALL occur on the first edge at which count_o<DEPTH.
REQ-017 The full test SHALL use count_o before any same-cycle pop: a pop in the full cycle does not allow a push in that cycle.
REQ-018 DEASSERT with req_s=1 SHALL hold ack_o=1, perform no writes and stay in DEASSERT.
REQ-019 DEASSERT with req_s=0 SHALL clear ack_o on the next edge and return to IDLE.
REQ-020 Exactly one buffer write SHALL occur per four-phase transaction.
REQ-021 Latency SHALL be SYNC_STAGES+1 clk edges from req_i rising (captured by the first sync flop) to ack_o=1, with buffer not full.
REQ-022 recv_vld_o and count_o SHALL update on the same edge that sets ack_o.
REQ-023 A pop SHALL occur when recv_vld_o=1 and recv_rdy_i=1; recv_rdy_i with empty buffer SHALL have no effect.
REQ-024 Simultaneous push and pop with 0<count_o<DEPTH SHALL leave count_o unchanged and advance both pointers.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; entries SHALL be delivered in arrival order.
REQ-026 recv_data_o SHALL be all-zero whenever recv_vld_o=0.
REQ-027 recv_vld_o SHALL equal (count_o != 0).

Reset
REQ-028 rst=1 at a clock edge SHALL clear all synchroniser flops, set state IDLE, ack_o=0, count_o=0, recv_vld_o=0, recv_data_o=0 and both pointers to 0.
REQ-029 Reset asserted mid-transaction SHALL discard buffered entries and the in-progress handshake; a req_i still high after reset SHALL be captured as a new transaction.
REQ-030 No output SHALL change asynchronously to clk.

Verification
REQ-031 Single transfer, SYNC_STAGES=2, recv_rdy_i=1: req_i rises with data 0xA5A5_0001 -> ack_o=1 on the 3rd edge, recv_vld_o=1 and recv_data_o=0xA5A5_0001 on that edge, popped next edge, count_o returns to 0; req_i low -> ack_o=0 three edges later.
REQ-032 Fill, DEPTH=4, recv_rdy_i=0: five transactions with data 1..5 -> first four acked, count_o=4, fifth req held with ack_o=0; one pop -> fifth captured on a following edge, drained order 1,2,3,4,5.
REQ-033 Full with same-cycle pop: count_o=4, req_s=1, recv_rdy_i=1 one cycle -> that edge count_o=3, no push; next edge push, count_o=4.
REQ-034 Long req: req_i held high 20 cycles -> exactly one entry written, ack_o high until 3 edges after req_i falls.
REQ-035 Wrap-around: 10 back-to-back transactions with recv_rdy_i toggling every cycle -> all 10 values delivered in order, count_o never exceeds 4.
REQ-036 Reset mid-operation: rst=1 for one edge with count_o=2 and ack_o=1 -> next cycle count_o=0, ack_o=0, recv_vld_o=0, recv_data_o=0.
